// File: rtl/fifo8_port_arbiter.sv
// -----------------------------------------------------------------------------
// fifo8_port_arbiter
//
// Single-operation-per-cycle controller in front of an 8-entry FIFO with one
// write port and one read port. Two producers (A, B) share the write port and
// one consumer uses the read port. The block tracks occupancy so the FIFO is
// never overflowed or underflowed, and it registers the consumer's read-valid.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   a_req/a_data/a_gnt    producer A request, data, grant (grant is combinational)
//   b_req/b_data/b_gnt    producer B request, data, grant (grant is combinational)
//   rd_req/rd_gnt         consumer pop request and grant (grant is combinational)
//   rd_valid/rd_data      popped word, valid the cycle after rd_gnt
//   fifo_wen/ren/din      FIFO write enable, read enable, write data
//   fifo_dout/fifo_error  FIFO read data (one cycle after ren) and error flag
//   count/full/empty      current occupancy and its limit flags
//   err_sticky            latched fifo_error, cleared only by rst
// -----------------------------------------------------------------------------
module fifo8_port_arbiter #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic [DW-1:0] a_data,
    output logic          a_gnt,
    input  logic          b_req,
    input  logic [DW-1:0] b_data,
    output logic          b_gnt,
    input  logic          rd_req,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          fifo_wen,
    output logic          fifo_ren,
    output logic [DW-1:0] fifo_din,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_error,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          err_sticky
);

    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_e;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    logic [CW-1:0] count_q, count_d;
    rr_e           rr_ptr_q, rr_ptr_d;
    logic          last_rd_q;
    logic          rd_valid_q;
    logic          err_sticky_q, err_sticky_d;

    logic          wr_elig_s;
    logic          rd_elig_s;
    logic          a_gnt_s;
    logic          b_gnt_s;
    logic          rd_gnt_s;

    // Grant selection: read/write alternation on contention, then A/B round robin.
    always_comb begin
        a_gnt_s   = 1'b0;
        b_gnt_s   = 1'b0;
        rd_gnt_s  = 1'b0;
        wr_elig_s = (a_req | b_req) & (count_q < DEPTH_C);
        rd_elig_s = rd_req & (count_q != ZERO_C);
        if (rst) begin
            // Grants must drop the moment reset rises, not at the next edge.
            rd_gnt_s = 1'b0;
        end else if (rd_elig_s && (!wr_elig_s || !last_rd_q)) begin
            rd_gnt_s = 1'b1;
        end else if (wr_elig_s) begin
            if (a_req && b_req) begin
                if (rr_ptr_q == RR_A) begin
                    a_gnt_s = 1'b1;
                end else begin
                    b_gnt_s = 1'b1;
                end
            end else if (a_req) begin
                a_gnt_s = 1'b1;
            end else begin
                b_gnt_s = 1'b1;
            end
        end else begin
            rd_gnt_s = 1'b0;
        end
    end

    // Next-state for occupancy, round-robin pointer and sticky error.
    always_comb begin
        count_d      = count_q;
        rr_ptr_d     = rr_ptr_q;
        err_sticky_d = err_sticky_q | fifo_error;
        if (a_gnt_s) begin
            count_d  = count_q + ONE_C;
            rr_ptr_d = RR_B;
        end else if (b_gnt_s) begin
            count_d  = count_q + ONE_C;
            rr_ptr_d = RR_A;
        end else if (rd_gnt_s) begin
            count_d  = count_q - ONE_C;
        end else begin
            count_d  = count_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= ZERO_C;
            rr_ptr_q     <= RR_A;
            last_rd_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            rr_ptr_q     <= rr_ptr_d;
            last_rd_q    <= rd_gnt_s;
            rd_valid_q   <= rd_gnt_s;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign a_gnt      = a_gnt_s;
    assign b_gnt      = b_gnt_s;
    assign rd_gnt     = rd_gnt_s;
    assign fifo_wen   = a_gnt_s | b_gnt_s;
    assign fifo_ren   = rd_gnt_s;
    assign fifo_din   = a_gnt_s ? a_data : b_data;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = fifo_dout;
    assign count      = count_q;
    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == ZERO_C);
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_fifo8_port_arbiter.sv
module tb_fifo8_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_req = 1'b0, b_req = 1'b0, rd_req = 1'b0;
    logic [7:0] a_data = 8'd0, b_data = 8'd0;
    logic       a_gnt, b_gnt, rd_gnt, rd_valid;
    logic [7:0] rd_data, fifo_din;
    logic [7:0] fifo_dout = 8'd0;
    logic       fifo_wen, fifo_ren;
    logic       fifo_error = 1'b0;
    logic [3:0] count;
    logic       full, empty, err_sticky;

    int tests = 0;
    int fails = 0;

    fifo8_port_arbiter #(.DW(8), .DEPTH(8), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_data(b_data), .b_gnt(b_gnt),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_wen(fifo_wen), .fifo_ren(fifo_ren), .fifo_din(fifo_din),
        .fifo_dout(fifo_dout), .fifo_error(fifo_error),
        .count(count), .full(full), .empty(empty), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO stand-in (environment) ----------------
    logic [7:0] fq[$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            fifo_dout <= 8'd0;
        end else begin
            if (fifo_ren && fq.size() > 0) fifo_dout <= fq.pop_front();
            if (fifo_wen) fq.push_back(fifo_din);
        end
    end

    // ---------------- Behavioural model ----------------
    int         m_count = 0;
    bit         m_next_b = 0;   // 1: B is favoured on an A/B tie
    bit         m_prev_rd = 0;  // previous cycle was a pop
    bit         m_rdv = 0;
    logic [7:0] m_rdd = 8'd0;
    bit         m_err = 0;
    logic [7:0] mq[$];

    // 0 none, 1 A, 2 B, 3 read
    function automatic int winner();
        bit can_w, can_r;
        int wsel;
        can_w = (a_req || b_req) && (m_count < 8);
        can_r = rd_req && (m_count > 0);
        wsel = 0;
        if (a_req && b_req) wsel = m_next_b ? 2 : 1;
        else if (a_req)     wsel = 1;
        else if (b_req)     wsel = 2;
        if (can_r && can_w) return m_prev_rd ? wsel : 3;
        if (can_r) return 3;
        if (can_w) return wsel;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        int w;
        if (rst) begin
            m_count = 0; m_next_b = 0; m_prev_rd = 0; m_rdv = 0; m_err = 0;
            mq.delete();
        end else begin
            w = winner();
            if (fifo_error) m_err = 1;
            m_rdv = (w == 3);
            m_prev_rd = (w == 3);
            case (w)
                1: begin mq.push_back(a_data); m_count++; m_next_b = 1; end
                2: begin mq.push_back(b_data); m_count++; m_next_b = 0; end
                3: begin m_rdd = mq.pop_front(); m_count--; end
                default: ;
            endcase
        end
    end

    // ---------------- Per-cycle compare ----------------
    always @(negedge clk) begin
        int w;
        if (rst) begin
            chk("rst_gnt", {a_gnt, b_gnt, rd_gnt, fifo_wen, fifo_ren}, 32'd0);
        end else begin
            w = winner();
            chk("a_gnt", a_gnt, (w == 1));
            chk("b_gnt", b_gnt, (w == 2));
            chk("rd_gnt", rd_gnt, (w == 3));
            chk("fifo_wen", fifo_wen, (w == 1 || w == 2));
            chk("fifo_ren", fifo_ren, (w == 3));
            chk("wen_ren_excl", fifo_wen & fifo_ren, 32'd0);
            if (w == 1 || w == 2) chk("fifo_din", fifo_din, (w == 1) ? a_data : b_data);
            chk("count", count, m_count);
            chk("full", full, (m_count == 8));
            chk("empty", empty, (m_count == 0));
            chk("rd_valid", rd_valid, m_rdv);
            if (m_rdv) chk("rd_data", rd_data, m_rdd);
            chk("err_sticky", err_sticky, m_err);
        end
    end

    // ---------------- Directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_req = 1'b0; b_req = 1'b0; rd_req = 1'b0; fifo_error = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    logic [7:0] t1_vals [8];

    initial begin
        t1_vals = '{8'd56, 8'd11, 8'd42, 8'd10, 8'd23, 8'd20, 8'd6, 8'd85};
        #1;
        chk("reset_count", count, 32'd0);
        chk("reset_empty", empty, 32'd1);
        chk("reset_rdvalid", rd_valid, 32'd0);
        chk("reset_err", err_sticky, 32'd0);

        // T1: fill from A
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a_req = 1'b1; a_data = t1_vals[i];
            #3 chk("t1_a_gnt", a_gnt, 32'd1);
            cyc();
        end
        chk("t1_count", count, 32'd8);
        chk("t1_full", full, 32'd1);
        #1 chk("t1_9th_gnt", a_gnt, 32'd0);
        cyc();
        a_req = 1'b0;
        rd_req = 1'b1;
        repeat (8) cyc();
        chk("t1_last_data", rd_data, 32'd85);
        rd_req = 1'b0;
        cyc();
        chk("t1_drained", empty, 32'd1);

        // T2: round robin
        do_reset();
        a_req = 1'b1; b_req = 1'b1; a_data = 8'hA1; b_data = 8'hB2;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("t2_a_gnt", a_gnt, (i % 2 == 0));
            chk("t2_b_gnt", b_gnt, (i % 2 == 1));
            cyc();
        end
        chk("t2_count", count, 32'd4);
        a_req = 1'b0; b_req = 1'b0;
        rd_req = 1'b1;
        repeat (5) cyc();
        rd_req = 1'b0;

        // T3: empty pop
        do_reset();
        rd_req = 1'b1;
        #3 chk("t3_no_gnt", rd_gnt, 32'd0);
        cyc();
        chk("t3_no_valid", rd_valid, 32'd0);
        a_req = 1'b1; a_data = 8'd45;
        #3;
        chk("t3_a_gnt", a_gnt, 32'd1);
        chk("t3_rd_held", rd_gnt, 32'd0);
        cyc();
        a_req = 1'b0;
        #1 chk("t3_rd_gnt", rd_gnt, 32'd1);
        cyc();
        rd_req = 1'b0;
        chk("t3_rd_valid", rd_valid, 32'd1);
        chk("t3_rd_data", rd_data, 32'd45);

        // T4: read/write contention
        do_reset();
        a_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data = 8'h30 + 8'(i);
            cyc();
        end
        a_data = 8'h40;
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_count", count, (i % 2 == 0) ? 32'd3 : 32'd2);
            #3;
            chk("t4_rd_gnt", rd_gnt, (i % 2 == 0));
            chk("t4_a_gnt", a_gnt, (i % 2 == 1));
            cyc();
        end
        a_req = 1'b0; rd_req = 1'b0;

        // T5: reset mid-operation
        do_reset();
        a_req = 1'b1; a_data = 8'h55;
        repeat (5) cyc();
        chk("t5_pre_count", count, 32'd5);
        #1 rst = 1'b1;
        #1;
        chk("t5_gnt_drop", a_gnt, 32'd0);
        chk("t5_count_clr", count, 32'd0);
        cyc();
        rst = 1'b0;
        b_req = 1'b1; b_data = 8'h66;
        chk("t5_empty", empty, 32'd1);
        #2;
        chk("t5_first_a", a_gnt, 32'd1);
        chk("t5_not_b", b_gnt, 32'd0);
        cyc();
        a_req = 1'b0; b_req = 1'b0;
        cyc();

        // T6: error
        do_reset();
        a_req = 1'b1; a_data = 8'h77; fifo_error = 1'b1;
        #3 chk("t6_err_before", err_sticky, 32'd0);
        cyc();
        fifo_error = 1'b0;
        chk("t6_err_set", err_sticky, 32'd1);
        #3 chk("t6_gnt_ok", a_gnt, 32'd1);
        cyc();
        a_req = 1'b0;
        repeat (3) cyc();
        chk("t6_err_hold", err_sticky, 32'd1);
        do_reset();
        chk("t6_err_clr", err_sticky, 32'd0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
